traffic_phase_sched: RTL and testbench
======================================

# traffic_phase_sched

Phase scheduler for a two-approach signalised intersection. It sequences the A and B approaches through green, yellow, left-turn and all-red phases, using a BCD countdown advanced by a 1 Hz strobe. It also services latched pedestrian requests and an emergency preemption input. Its outputs drive the lamp and countdown-display datapath directly, with lamp codes red=8, yellow=4, green=2, left=1.

## Interface
- T_GREEN, 8'h40: green duration, 2-digit BCD, 01–99
- T_YELLOW, 8'h05: yellow duration, BCD
- T_LEFT, 8'h15: left-turn duration, BCD
- T_ALLRED, 8'h02: all-red clearance duration, BCD
- T_PED, 8'h20: minimum green when a walk is served, BCD
- CLK  in  1  system clock
- RST  in  1  reset; synchronous, active-high
- TICK  in  1  one-cycle strobe, 1 Hz
- EN  in  1  1 = normal sequencing, 0 = disabled mode
- PED_REQA, PED_REQB  in  1  pedestrian request pulses, one per approach
- PREEMPT  in  1  emergency preemption; level-sensitive
- LAMPA, LAMPB  out  4  lamp codes; exactly one bit is set
- WALKA, WALKB  out  1  walk signals
- COUNT  out  8  remaining seconds, BCD
- PHASE  out  4  current state code

## Operation
- States and codes:
  - A_GRN 0, A_YEL1 1, A_LEFT 2, A_YEL2 3, A_RED 4
  - B_GRN 5, B_YEL1 6, B_LEFT 7, B_YEL2 8, B_RED 9
  - PRE_HOLD 10, DISABLED 11
- Normal cycle: A_GRN→A_YEL1→A_LEFT→A_YEL2→A_RED→B_GRN→B_YEL1→B_LEFT→B_YEL2→B_RED→A_GRN.
- Lamps:
  - A_* non-red states drive LAMPA = 2/4/1/4; LAMPB=8 throughout.
  - B_* states mirror this.
  - A_RED, B_RED and PRE_HOLD drive both lamps to 8.
- Entering a timed state loads COUNT with that state's duration. *_GRN uses T_GREEN, or max(T_GREEN,T_PED) when a walk is served. *_RED uses T_ALLRED.
- On TICK, when COUNT≠01: COUNT decrements in BCD. If the low nibble is 0, it becomes 9 and the high nibble decrements; otherwise the low nibble decrements.
- On TICK, when COUNT=01: the block advances to the next state and loads that state's duration.
- Pedestrian requests:
  - PED_REQx sets a sticky latch pendx.
  - On entry to x_GRN with pendx=1: pendx clears and WALKx is high for the whole of x_GRN.
  - WALKx is low in every other state.
  - A request arriving during x_GRN is held for the next cycle.
- Preemption (PREEMPT=1):
  - From any GRN or LEFT state: go immediately to that approach's YEL1 or YEL2 with COUNT=T_YELLOW.
  - A YEL state in progress finishes its countdown.
  - Any YEL state or *_RED state then exits to PRE_HOLD instead of its normal successor.
  - PRE_HOLD: both lamps red, COUNT=00, held while PREEMPT=1.
  - PREEMPT=0 in PRE_HOLD: go to B_RED (T_ALLRED), then resume at A_GRN.
- Disabled mode:
  - EN=0 from any state forces DISABLED on the next edge. Walk latches clear and COUNT=00.
  - EN returning to 1 enters B_RED with COUNT=T_ALLRED.
- Priority: RST > EN=0 > PREEMPT > TICK countdown.

## Timing
- Reset values (one edge with RST=1):
  - state B_RED, COUNT=T_ALLRED, PHASE=9
  - LAMPA=LAMPB=8, WALKA=WALKB=0, pend latches 0
- All outputs are registered and change one CLK after the causing input is sampled.
- A TICK at COUNT=01 produces the new state, the new COUNT and the new lamps on the same edge. There is no intermediate cycle.
- A preempt exit from GRN/LEFT lands in YEL one cycle after PREEMPT is sampled, regardless of TICK.
- PREEMPT and TICK in the same cycle: the preempt transition is taken and the decrement is discarded.
- PED_REQx in the same cycle as entry to x_GRN is not served; it stays pending.
- A state exposes exactly N TICKs for a loaded value N. A state never exits without a TICK, except under preempt, EN or RST.
- RST mid-phase aborts immediately to the reset state.

## Configuration
- FLASH_YELLOW_EN defined: in DISABLED, LAMPA=LAMPB toggle between 4 and 0 on each TICK, starting at 4.
- FLASH_YELLOW_EN undefined: in DISABLED, LAMPA=LAMPB=8 steadily.
- The macro changes nothing outside DISABLED.

## Test plan
- Reset, EN=1, TICK every cycle, defaults: B_RED 2 ticks → A_GRN COUNT=40 → after 40 ticks A_YEL1 COUNT=05 with LAMPA=4, LAMPB=8. Check the full 10-state cycle order.
- BCD boundary: COUNT=40, one TICK → 39; COUNT=10 → 09; 01 → advance. No hex values (3F, 0F) ever appear.
- PED_REQA pulse during B_LEFT with T_GREEN=10, T_PED=20 → A_GRN loads 20, WALKA=1 for 20 ticks, then 0 in A_YEL1; pendA cleared.
- PREEMPT asserted at A_GRN COUNT=30 → next edge A_YEL1 COUNT=05 → after 5 ticks PRE_HOLD, both lamps 8. Release → B_RED 2 ticks → A_GRN.
- EN=0 mid A_LEFT → DISABLED, COUNT=00. Lamps toggle 4/0 per TICK with FLASH_YELLOW_EN, steady 8 without it. EN=1 → B_RED COUNT=02.
- RST asserted mid B_GRN together with PREEMPT and TICK → reset values on the next edge. PREEMPT still high afterwards → B_RED exits to PRE_HOLD after 2 ticks.

Source files
------------

// File: rtl/traffic_phase_sched.sv
// Two-approach signal phase scheduler: BCD countdown on a 1 Hz strobe, pedestrian walk service,
// emergency preemption and a disabled mode. Optional `FLASH_YELLOW_EN flashes yellow while disabled.
module traffic_phase_sched #(
    parameter logic [7:0] T_GREEN  = 8'h40,
    parameter logic [7:0] T_YELLOW = 8'h05,
    parameter logic [7:0] T_LEFT   = 8'h15,
    parameter logic [7:0] T_ALLRED = 8'h02,
    parameter logic [7:0] T_PED    = 8'h20
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK,
    input  logic       EN,
    input  logic       PED_REQA,
    input  logic       PED_REQB,
    input  logic       PREEMPT,
    output logic [3:0] LAMPA,
    output logic [3:0] LAMPB,
    output logic       WALKA,
    output logic       WALKB,
    output logic [7:0] COUNT,
    output logic [3:0] PHASE
);
    typedef enum logic [3:0] {
        A_GRN = 4'd0, A_YEL1 = 4'd1, A_LEFT = 4'd2, A_YEL2 = 4'd3, A_RED = 4'd4,
        B_GRN = 4'd5, B_YEL1 = 4'd6, B_LEFT = 4'd7, B_YEL2 = 4'd8, B_RED = 4'd9,
        PRE_HOLD = 4'd10, DISABLED = 4'd11
    } state_t;

    localparam logic [3:0] L_RED = 4'd8, L_YEL = 4'd4, L_GRN = 4'd2, L_LEFT = 4'd1;
    // Valid BCD orders the same as binary, so a plain compare gives the max.
    localparam logic [7:0] T_GRN_WALK = (T_PED > T_GREEN) ? T_PED : T_GREEN;

    state_t     state, state_nx;
    logic [7:0] count, count_nx;
    logic       pend_a, pend_b, pend_a_nx, pend_b_nx;
    logic       walk_a, walk_b, walk_a_nx, walk_b_nx;

    function automatic state_t succ(input state_t s);
        case (s)
            A_GRN:   succ = A_YEL1;
            A_YEL1:  succ = A_LEFT;
            A_LEFT:  succ = A_YEL2;
            A_YEL2:  succ = A_RED;
            A_RED:   succ = B_GRN;
            B_GRN:   succ = B_YEL1;
            B_YEL1:  succ = B_LEFT;
            B_LEFT:  succ = B_YEL2;
            B_YEL2:  succ = B_RED;
            B_RED:   succ = A_GRN;
            default: succ = B_RED;
        endcase
    endfunction

    function automatic logic [7:0] dur(input state_t s);
        case (s)
            A_GRN, B_GRN:                  dur = T_GREEN;
            A_YEL1, A_YEL2, B_YEL1, B_YEL2: dur = T_YELLOW;
            A_LEFT, B_LEFT:                dur = T_LEFT;
            A_RED, B_RED:                  dur = T_ALLRED;
            default:                       dur = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) bcd_dec = {v[7:4] - 4'd1, 4'd9};
        else                bcd_dec = {v[7:4], v[3:0] - 4'd1};
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= B_RED;
            count  <= T_ALLRED;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
            walk_a <= 1'b0;
            walk_b <= 1'b0;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            pend_a <= pend_a_nx;
            pend_b <= pend_b_nx;
            walk_a <= walk_a_nx;
            walk_b <= walk_b_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        pend_a_nx = pend_a | PED_REQA;
        pend_b_nx = pend_b | PED_REQB;
        walk_a_nx = walk_a;
        walk_b_nx = walk_b;
        if (!EN) begin
            state_nx  = DISABLED;
            count_nx  = 8'h00;
            pend_a_nx = 1'b0;
            pend_b_nx = 1'b0;
        end else if (state == DISABLED) begin
            state_nx = B_RED;
            count_nx = T_ALLRED;
        end else if (state == PRE_HOLD) begin
            if (!PREEMPT) begin
                state_nx = B_RED;
                count_nx = T_ALLRED;
            end
        end else if (PREEMPT && (state == A_GRN || state == A_LEFT ||
                                 state == B_GRN || state == B_LEFT)) begin
            state_nx = succ(state);
            count_nx = T_YELLOW;
        end else if (TICK) begin
            if (count == 8'h01) begin
                // Only YEL/RED states reach here with PREEMPT high.
                state_nx = PREEMPT ? PRE_HOLD : succ(state);
                count_nx = dur(state_nx);
            end else begin
                count_nx = bcd_dec(count);
            end
        end
        // A walk is decided once, at green entry, from the latch as it stood before this cycle.
        if (state_nx != state) begin
            walk_a_nx = (state_nx == A_GRN) && pend_a;
            walk_b_nx = (state_nx == B_GRN) && pend_b;
            if (walk_a_nx) begin
                pend_a_nx = PED_REQA;
                count_nx  = T_GRN_WALK;
            end
            if (walk_b_nx) begin
                pend_b_nx = PED_REQB;
                count_nx  = T_GRN_WALK;
            end
        end
    end

    logic [3:0] lamp_dis;
`ifdef FLASH_YELLOW_EN
    logic flash;
    always_ff @(posedge CLK) begin
        if (RST || state != DISABLED) flash <= 1'b1;
        else if (TICK)                flash <= ~flash;
    end
    assign lamp_dis = flash ? L_YEL : 4'd0;
`else
    assign lamp_dis = L_RED;
`endif

    always_comb begin
        LAMPA = L_RED;
        LAMPB = L_RED;
        case (state)
            A_GRN:            LAMPA = L_GRN;
            A_YEL1, A_YEL2:   LAMPA = L_YEL;
            A_LEFT:           LAMPA = L_LEFT;
            B_GRN:            LAMPB = L_GRN;
            B_YEL1, B_YEL2:   LAMPB = L_YEL;
            B_LEFT:           LAMPB = L_LEFT;
            DISABLED: begin
                LAMPA = lamp_dis;
                LAMPB = lamp_dis;
            end
            default: ;
        endcase
        WALKA = walk_a;
        WALKB = walk_b;
        COUNT = count;
        PHASE = state;
    end
endmodule

// File: tb/tb_traffic_phase_sched.sv
// Scoreboard bench for traffic_phase_sched: directed stimulus queues expected snapshots, a negedge
// monitor compares them. Built with T_GREEN=10, T_PED=20 so walk service lengthens green.
module tb_traffic_phase_sched;
    logic       CLK = 1'b0;
    logic       RST, TICK, EN, PED_REQA, PED_REQB, PREEMPT;
    logic [3:0] LAMPA, LAMPB, PHASE;
    logic       WALKA, WALKB;
    logic [7:0] COUNT;

    always #5 CLK = ~CLK;

    traffic_phase_sched #(.T_GREEN(8'h10), .T_PED(8'h20)) dut (
        .CLK(CLK), .RST(RST), .TICK(TICK), .EN(EN), .PED_REQA(PED_REQA), .PED_REQB(PED_REQB),
        .PREEMPT(PREEMPT), .LAMPA(LAMPA), .LAMPB(LAMPB), .WALKA(WALKA), .WALKB(WALKB),
        .COUNT(COUNT), .PHASE(PHASE)
    );

    typedef struct {
        string      name;
        int         cyc;
        logic [3:0] ph;
        logic [7:0] cnt;
        logic [3:0] la, lb;
        logic       wa, wb;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   cyc = 0, n_chk = 0, n_pass = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            n_chk++;
            if (PHASE === e.ph && COUNT === e.cnt && LAMPA === e.la && LAMPB === e.lb &&
                WALKA === e.wa && WALKB === e.wb)
                n_pass++;
            else
                $display("FAIL %s: got ph=%0d cnt=%h la=%0d lb=%0d wa=%b wb=%b, want ph=%0d cnt=%h la=%0d lb=%0d wa=%b wb=%b",
                         e.name, PHASE, COUNT, LAMPA, LAMPB, WALKA, WALKB,
                         e.ph, e.cnt, e.la, e.lb, e.wa, e.wb);
        end
    end

    function automatic logic [7:0] lamps(input int ph);
        case (ph)
            0: lamps = 8'h28;  1: lamps = 8'h48;  2: lamps = 8'h18;  3: lamps = 8'h48;
            5: lamps = 8'h82;  6: lamps = 8'h84;  7: lamps = 8'h81;  8: lamps = 8'h84;
            default: lamps = 8'h88;
        endcase
    endfunction

    function automatic int b2i(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic push(input string nm, input int ph, input logic [7:0] cnt,
                        input logic [7:0] lmp, input logic wa, input logic wb);
        exp_t x;
        x.name = nm; x.cyc = cyc; x.ph = 4'(ph); x.cnt = cnt;
        x.la = lmp[7:4]; x.lb = lmp[3:0]; x.wa = wa; x.wb = wb;
        sbq.push_back(x);
    endtask

    task automatic chk(input string nm, input int ph, input logic [7:0] cnt,
                       input logic wa = 1'b0, input logic wb = 1'b0);
        push(nm, ph, cnt, lamps(ph), wa, wb);
    endtask

    task automatic chk_dis(input string nm, input bit lit);
`ifdef FLASH_YELLOW_EN
        push(nm, 11, 8'h00, lit ? 8'h44 : 8'h00, 1'b0, 1'b0);
`else
        push(nm, 11, 8'h00, 8'h88, 1'b0, 1'b0);
`endif
    endtask

    task automatic step(input bit tk);
        TICK = tk;
        @(posedge CLK);
        #1;
        TICK = 1'b0; PED_REQA = 1'b0; PED_REQB = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1);
    endtask

    int         cph[9]  = '{2, 3, 4, 5, 6, 7, 8, 9, 0};
    logic [7:0] ccnt[9] = '{8'h15, 8'h05, 8'h02, 8'h10, 8'h05, 8'h15, 8'h05, 8'h02, 8'h10};

    initial begin
        int prev;
        RST = 1'b1; EN = 1'b1; TICK = 1'b0; PED_REQA = 1'b0; PED_REQB = 1'b0; PREEMPT = 1'b0;
        step(1'b0);
        chk("reset", 9, 8'h02);
        RST = 1'b0;
        step(1'b1); chk("b_red_dec", 9, 8'h01);
        step(1'b1); chk("a_grn_entry", 0, 8'h10);
        step(1'b1); chk("bcd_10_09", 0, 8'h09);
        step(1'b0); chk("no_tick_hold", 0, 8'h09);
        ticks(8);   chk("a_grn_01", 0, 8'h01);
        step(1'b1); chk("a_yel1_entry", 1, 8'h05);
        prev = 5;
        for (int i = 0; i < 9; i++) begin
            ticks(prev);
            chk($sformatf("cycle_%0d", cph[i]), cph[i], ccnt[i]);
            prev = b2i(ccnt[i]);
        end

        // Walk request during B_LEFT lengthens the next A green.
        ticks(52);  chk("b_left", 7, 8'h15);
        PED_REQA = 1'b1;
        step(1'b1); chk("b_left_req", 7, 8'h14);
        ticks(14);  chk("b_yel2", 8, 8'h05);
        ticks(7);   chk("a_grn_walk", 0, 8'h20, 1'b1);
        ticks(19);  chk("a_grn_walk_01", 0, 8'h01, 1'b1);
        step(1'b1); chk("a_yel1_nowalk", 1, 8'h05);
        ticks(64);  chk("a_grn_pend_clr", 0, 8'h10);
        PED_REQA = 1'b1;
        step(1'b1); chk("req_in_green", 0, 8'h09);
        ticks(73);  chk("a_grn_held_req", 0, 8'h20, 1'b1);

        // Preemption from green with a coincident TICK.
        ticks(5);   chk("a_grn_15", 0, 8'h15, 1'b1);
        PREEMPT = 1'b1;
        step(1'b1); chk("pre_grn_yel1", 1, 8'h05);
        ticks(4);   chk("pre_yel1_01", 1, 8'h01);
        step(1'b1); chk("pre_hold", 10, 8'h00);
        ticks(3);   chk("pre_hold_stay", 10, 8'h00);
        PREEMPT = 1'b0;
        step(1'b0); chk("pre_release", 9, 8'h02);
        ticks(2);   chk("resume_a_grn", 0, 8'h10);

        // Disabled mode mid A_LEFT; a request in the same cycle is dropped.
        ticks(15);  chk("a_left", 2, 8'h15);
        ticks(3);   chk("a_left_12", 2, 8'h12);
        EN = 1'b0; PED_REQB = 1'b1;
        step(1'b1); chk_dis("dis_entry", 1'b1);
        step(1'b1); chk_dis("dis_tick1", 1'b0);
        step(1'b1); chk_dis("dis_tick2", 1'b1);
        step(1'b0); chk_dis("dis_notick", 1'b1);
        EN = 1'b1;
        step(1'b0); chk("en_b_red", 9, 8'h02);
        ticks(2);   chk("en_a_grn", 0, 8'h10);

        // Preempt from LEFT, released before yellow ends: normal successor.
        ticks(15);  chk("a_left2", 2, 8'h15);
        PREEMPT = 1'b1;
        step(1'b0); chk("pre_left_yel2", 3, 8'h05);
        PREEMPT = 1'b0;
        ticks(5);   chk("yel2_normal", 4, 8'h02);
        ticks(2);   chk("b_grn_nowalk", 5, 8'h10);
        ticks(3);   chk("b_grn_07", 5, 8'h07);

        // Reset beats preempt and tick; preempt still high afterwards.
        RST = 1'b1; PREEMPT = 1'b1;
        step(1'b1); chk("rst_mid", 9, 8'h02);
        RST = 1'b0;
        step(1'b1); chk("rst_b_red_01", 9, 8'h01);
        step(1'b1); chk("rst_pre_hold", 10, 8'h00);
        PREEMPT = 1'b0; PED_REQB = 1'b1;
        step(1'b0); chk("rst_release", 9, 8'h02);
        ticks(2);   chk("rst_a_grn", 0, 8'h10);
        ticks(37);  chk("b_grn_walk", 5, 8'h20, 1'b0, 1'b1);

        step(1'b0);
        step(1'b0);
        if (sbq.size() != 0) begin
            n_chk++;
            $display("FAIL sb_drain: %0d entries left, want 0", sbq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
